// File: rtl/imem_ctrl.sv
// ============================================================================
// Module   : imem_ctrl
// Brief    : Instruction-memory controller. Serves one IF fetch per cycle and
//            loads programs into the instruction RAM. The optional zero-fill
//            CLEAR phase after reset is enabled by defining IMEM_CLEAR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_ctrl #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [31:0]   if_addr,
   output logic          if_valid,
   output logic [31:0]   if_data,
   output logic          if_stall,
   output logic          if_fault,
   input  logic          ld_start,
   input  logic          ld_valid,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [31:0]   ram_wdata,
   input  logic [31:0]   ram_rdata
);

`ifdef IMEM_CLEAR_EN
   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_t;
   localparam state_t c_RST_STATE = S_CLEAR;
   localparam logic   c_RST_STALL = 1'b1;
`else
   typedef enum logic [1:0] {
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2
   } state_t;
   localparam state_t c_RST_STATE = S_RUN;
   localparam logic   c_RST_STALL = 1'b0;
`endif

   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   state_t        r_state, w_state_nxt;
   logic [AW-1:0] r_ptr, w_ptr_nxt;
   logic          r_valid, r_fault;
   logic          w_fetch, w_oor;
   logic          w_unused_addr;

   assign w_oor         = |if_addr[31:AW+2];
   assign w_unused_addr = &{1'b0, if_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_RST_STATE;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_valid <= w_fetch;
         r_fault <= w_fetch & w_oor;
      end
   end

   // RAM-side outputs are combinational so a fetch sees exactly one cycle of
   // latency; rst forces them to their idle values while it is asserted.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_fetch     = 1'b0;
      ld_ready    = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      if_stall    = 1'b1;
      if (rst) begin
         if_stall = c_RST_STALL;
      end else begin
         case (r_state)
`ifdef IMEM_CLEAR_EN
            S_CLEAR: begin
               ram_we    = 1'b1;
               ram_addr  = r_ptr;
               w_ptr_nxt = r_ptr + 1'b1;
               if (r_ptr == c_LAST) begin
                  w_state_nxt = S_RUN;
                  w_ptr_nxt   = '0;
               end
            end
`endif
            S_LOAD: begin
               ld_ready = 1'b1;
               if (ld_valid) begin
                  ram_we    = 1'b1;
                  ram_addr  = r_ptr;
                  ram_wdata = ld_data;
                  w_ptr_nxt = r_ptr + 1'b1;
                  // The last RAM word ends the load so the pointer never wraps.
                  if (ld_last || (r_ptr == c_LAST)) begin
                     w_state_nxt = S_RUN;
                     w_ptr_nxt   = '0;
                  end
               end
            end
            S_RUN: begin
               if_stall = 1'b0;
               if (if_req) begin
                  w_fetch  = 1'b1;
                  ram_addr = if_addr[AW+1:2];
               end
               if (ld_start) begin
                  w_state_nxt = S_LOAD;
                  w_ptr_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = c_RST_STATE;
               w_ptr_nxt   = '0;
            end
         endcase
      end
   end

   assign if_valid = r_valid;
   assign if_fault = r_fault;
   assign if_data  = (r_valid && !r_fault) ? ram_rdata : 32'h0;

endmodule

`default_nettype wire

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
- REQ-001: Parameter DEPTH, default 128, instruction RAM depth in 32-bit words.
- REQ-002: Parameter AW, default 7, RAM word-address width; DEPTH SHALL equal 2**AW.
- REQ-003: clk  in  1  rising-edge clock.
- REQ-004: rst  in  1  reset, synchronous, active-high.
- REQ-005: if_req  in  1  fetch request from IF stage.
- REQ-006: if_addr  in  32  fetch byte address; word index = if_addr[AW+1:2].
- REQ-007: if_valid  out  1  if_data valid for the request of the previous cycle.
- REQ-008: if_data  out  32  fetched instruction.
- REQ-009: if_stall  out  1  high while fetch cannot be served (not in RUN).
- REQ-010: if_fault  out  1  with if_valid, request address was out of range.
- REQ-011: ld_start  in  1  pulse to begin a program load.
- REQ-012: ld_valid  in  1  loader word valid.
- REQ-013: ld_data  in  32  loader word.
- REQ-014: ld_last  in  1  with ld_valid, final word of the program.
- REQ-015: ld_ready  out  1  controller accepts the loader word this cycle.
- REQ-016: ram_addr  out  AW  RAM word address.
- REQ-017: ram_we  out  1  RAM write enable.
- REQ-018: ram_wdata  out  32  RAM write data.
- REQ-019: ram_rdata  in  32  RAM read data, one-cycle synchronous latency.

Function
- REQ-020: FSM states CLEAR, LOAD, RUN; exactly one active.
- REQ-021: CLEAR: write 32'h0 to addresses 0..DEPTH-1, one per cycle, from counter; after address DEPTH-1 go to RUN.
- REQ-022: RUN + ld_start -> LOAD, write pointer reset to 0; ld_start in CLEAR or LOAD ignored.
- REQ-023: LOAD: ld_ready=1; word transfers when ld_valid&&ld_ready, written to pointer, pointer +1.
- REQ-024: LOAD -> RUN after the transfer with ld_last=1 or the transfer to address DEPTH-1, whichever first; pointer never wraps.
- REQ-025: if_stall=1 in CLEAR and LOAD; 0 in RUN.
- REQ-026: RUN: if_req drives ram_addr=if_addr[AW+1:2], ram_we=0; if_valid=1 next cycle, if_data=ram_rdata.
- REQ-027: Fetch throughput one per cycle, latency exactly one cycle, back-to-back without bubbles.
- REQ-028: if_addr[31:AW+2] nonzero: no RAM read relied on; next cycle if_valid=1, if_fault=1, if_data=32'h0 (NOP).
- REQ-029: if_req while not RUN ignored; no if_valid produced.
- REQ-030: RUN with fetch in flight and ld_start same cycle: in-flight fetch completes with if_valid next cycle; new requests stall.
- REQ-031: ram_we SHALL be 1 only in CLEAR and on LOAD transfers; ld_ready=0 outside LOAD.

Reset
- REQ-032: rst in any state, including mid-CLEAR or mid-LOAD, SHALL on next edge set state CLEAR (RUN if IMEM_CLEAR_EN undefined), counters 0.
- REQ-033: Reset values: if_valid=0, if_fault=0, if_data=0, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0; if_stall=1 (0 without IMEM_CLEAR_EN).
- REQ-034: A partial load interrupted by rst SHALL NOT resume; a new ld_start is required.

Configuration
- REQ-035: Macro IMEM_CLEAR_EN defined: CLEAR state present, reset enters CLEAR, zero-fill takes DEPTH cycles.
- REQ-036: IMEM_CLEAR_EN undefined: CLEAR state removed, reset enters RUN directly, RAM contents untouched.

Verification
- REQ-037: Reset released with IMEM_CLEAR_EN -> 128 cycles ram_we=1 addresses 0..127 data 0, if_stall=1, then if_stall=0 in RUN.
- REQ-038: ld_start, 4 words 32'h00004020, 32'h00004820, 32'had280000, 32'h8d250000 (last) -> written to 0..3, then RUN; fetch 0x0,0x4,0x8,0xC back-to-back -> same words, one per cycle, 1-cycle latency.
- REQ-039: Load of 128 words without ld_last -> auto RUN after address 127, 129th ld_valid sees ld_ready=0.
- REQ-040: Fetch if_addr=32'h00000200 -> next cycle if_valid=1, if_fault=1, if_data=0.
- REQ-041: rst asserted after 2 of 4 load words -> CLEAR restarts from address 0, ld_ready=0, no resumed writes.
- REQ-042: ld_start same cycle as fetch of 0x8 -> if_valid with word 2 next cycle, then if_stall=1, ld_ready=1.
